// File: rtl/spi_pkg.sv
// Shared SPI receiver definitions: FSM encoding, mode constants and PmodCLS command bytes.
// Used by the receiver RTL, the bench and the master-side models.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_e;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CLS_ESC      = 8'h1B;
  localparam logic [BYTE_W-1:0] CLS_LBRACKET = 8'h5B;
  localparam logic [BYTE_W-1:0] CLS_CLEAR    = 8'h6A;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is on rd_dat_o whenever non-empty, 0 when empty.
// Simultaneous push and pop both take effect, so a pop makes room for a push even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = rd_rdy_i && (count_q != '0);
  assign do_push = wr_vld_i && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == FULL_CNT);
  assign count_o  = count_q;
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: oversampled SCLK/MOSI/SS_N, MSB-first byte capture into a show-ahead FIFO,
// frame/abort/overrun reporting and a per-byte response shifted out on MISO.
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  input  logic [BYTE_W-1:0] tx_data,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              frame_start,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_bytes,
  output logic              frame_abort,
  output logic              overrun
);

  logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
  logic ss_meta_q, ss_sync_q, ss_hist_q;
  logic mosi_meta_q, mosi_sync_q;
  logic [1:0] warm_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta_q <= SPI_CPOL;
      sclk_sync_q <= SPI_CPOL;
      sclk_hist_q <= SPI_CPOL;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_hist_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      warm_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_hist_q <= sclk_sync_q;
      ss_meta_q   <= ss_n;
      ss_sync_q   <= ss_meta_q;
      ss_hist_q   <= ss_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      // Preset sync values are not real samples; only arm once ss_n has truly been seen high.
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      if ((warm_q == 2'd2) && ss_sync_q) armed_q <= 1'b1;
    end
  end

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_rise = sclk_sync_q & ~sclk_hist_q;
  assign sclk_fall = ~sclk_sync_q & sclk_hist_q;
  assign ss_rise   = ss_sync_q & ~ss_hist_q;
  assign ss_fall   = armed_q & ~ss_sync_q & ss_hist_q;

  spi_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [BYTE_W-1:0] rx_sr_q;
  logic [BYTE_W-1:0] tx_sr_q;
  logic              reload_q;
  logic              miso_q;
  logic              frame_start_q, frame_done_q, frame_abort_q;
  logic [CNT_W-1:0]  frame_bytes_q;
  logic              overrun_q;

  logic              push_d;
  logic [BYTE_W-1:0] rx_byte_d;
  logic              fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign rx_byte_d = {rx_sr_q[BYTE_W-2:0], mosi_sync_q};
  assign push_d    = (state_q == ACTIVE) && !ss_rise && sclk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      reload_q      <= 1'b0;
      miso_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      frame_bytes_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      if (push_d && fifo_full && !rx_rd) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            reload_q      <= 1'b0;
            tx_sr_q       <= tx_data;
            miso_q        <= tx_data[BYTE_W-1];
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            if (bit_cnt_q == '0) begin
              frame_done_q  <= 1'b1;
              frame_bytes_q <= byte_cnt_q;
            end else begin
              frame_abort_q <= 1'b1;
            end
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr_q <= rx_byte_d;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              reload_q  <= 1'b1;
              if (byte_cnt_q != {CNT_W{1'b1}}) byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (sclk_fall) begin
            // The falling edge that ends a byte starts the next response byte.
            if (reload_q) begin
              tx_sr_q  <= tx_data;
              miso_q   <= tx_data[BYTE_W-1];
              reload_q <= 1'b0;
            end else begin
              tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
              miso_q  <= tx_sr_q[BYTE_W-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (push_d),
    .wr_dat_i (rx_byte_d),
    .rd_rdy_i (rx_rd),
    .rd_dat_o (rx_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

  assign rx_valid    = ~fifo_empty;
  assign miso        = miso_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign frame_bytes = frame_bytes_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: table of single-byte frames plus hand-written frame sequences.
module tb_spi_slave_receiver;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, ss_n, rx_rd;
  logic [7:0] tx_data;
  logic       miso, rx_valid, frame_start, frame_done, frame_abort, overrun;
  logic [7:0] rx_data;
  logic [5:0] frame_bytes;

  spi_slave_receiver #(.FIFO_DEPTH(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .frame_start(frame_start), .frame_done(frame_done), .frame_bytes(frame_bytes),
    .frame_abort(frame_abort), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_done = 0, n_abort = 0;

  always @(negedge clk) begin
    if (frame_start) n_start++;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  logic [7:0] mo_bytes [16];
  logic [7:0] mi_bytes [16];

  typedef struct {
    logic [7:0] mosi_b;
    logic [7:0] tx_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period of 16 clk; master samples miso just before its rising edge.
  // rd_on_push pulses rx_rd on the clock at which the DUT acts on this rising edge.
  task automatic spi_bit(input logic b, input bit rd_on_push, output logic mi);
    mosi = b;
    wait_clk(8);
    mi   = miso;
    sclk = 1'b1;
    if (rd_on_push) begin
      wait_clk(2);
      rx_rd = 1'b1;
      wait_clk(1);
      rx_rd = 1'b0;
      wait_clk(5);
    end else begin
      wait_clk(8);
    end
    sclk = 1'b0;
  endtask

  task automatic send_frame(input int n_full, input int n_part, input int rd_idx, input bit close);
    logic m;
    ss_n = 1'b0;
    wait_clk(8);
    for (int k = 0; k < n_full; k++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_bit(mo_bytes[k][i], (k == rd_idx) && (i == 0), m);
        mi_bytes[k][i] = m;
      end
    end
    for (int i = 7; i > 7 - n_part; i--) spi_bit(mo_bytes[n_full][i], 1'b0, m);
    if (close) begin
      wait_clk(8);
      ss_n = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, rx_valid, 1'b1);
    chk({name, "_data"}, rx_data, exp);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
  endtask

  int s0, d0, a0;

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; rx_rd = 1'b0; tx_data = 8'h00;
    vecs[0] = '{8'h1B, 8'hA5, 8'h1B, 8'hA5};
    vecs[1] = '{8'h5B, 8'h3C, 8'h5B, 8'h3C};
    vecs[2] = '{8'h6A, 8'hFF, 8'h6A, 8'hFF};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{8'hFF, 8'h81, 8'hFF, 8'h81};

    wait_clk(4);
    chk("rst_miso", miso, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_frame_bytes", frame_bytes, 6'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_pulses", {frame_start, frame_done, frame_abort}, 3'b000);
    rst = 1'b0;
    wait_clk(6);

    // PmodCLS clear-screen command, popped in order.
    mo_bytes[0] = CLS_ESC; mo_bytes[1] = CLS_LBRACKET; mo_bytes[2] = CLS_CLEAR;
    s0 = n_start; d0 = n_done;
    send_frame(3, 0, -1, 1'b1);
    chk("cls_start_once", n_start - s0, 1);
    chk("cls_done_once", n_done - d0, 1);
    chk("cls_frame_bytes", frame_bytes, 6'd3);
    pop_chk("cls_b0", 8'h1B);
    pop_chk("cls_b1", 8'h5B);
    pop_chk("cls_b2", 8'h6A);
    @(negedge clk);
    chk("cls_empty", rx_valid, 1'b0);

    for (int v = 0; v < 5; v++) begin
      tx_data = vecs[v].tx_b;
      mo_bytes[0] = vecs[v].mosi_b;
      d0 = n_done;
      send_frame(1, 0, -1, 1'b1);
      chk($sformatf("vec%0d_miso", v), mi_bytes[0], vecs[v].exp_miso);
      chk($sformatf("vec%0d_done", v), n_done - d0, 1);
      chk($sformatf("vec%0d_bytes", v), frame_bytes, 6'd1);
      pop_chk($sformatf("vec%0d_rx", v), vecs[v].exp_rx);
    end
    tx_data = 8'h00;

    // Partial second byte: abort, first byte kept, frame_bytes untouched.
    mo_bytes[0] = 8'h3C; mo_bytes[1] = 8'hFF;
    d0 = n_done; a0 = n_abort;
    send_frame(1, 5, -1, 1'b1);
    chk("abort_pulse", n_abort - a0, 1);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_frame_bytes", frame_bytes, 6'd1);
    pop_chk("abort_b0", 8'h3C);
    @(negedge clk);
    chk("abort_empty", rx_valid, 1'b0);

    // Six bytes into a four-entry FIFO with nobody reading.
    do_reset();
    chk("ovr_clear_after_rst", overrun, 1'b0);
    for (int k = 0; k < 6; k++) mo_bytes[k] = 8'(k + 1);
    send_frame(6, 0, -1, 1'b1);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_frame_bytes", frame_bytes, 6'd6);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("ovr_b%0d", k), 8'(k + 1));
    @(negedge clk);
    chk("ovr_empty", rx_valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);

    // Pop coincident with the fifth push on a full FIFO.
    do_reset();
    for (int k = 0; k < 5; k++) mo_bytes[k] = 8'(8'h11 + k);
    send_frame(5, 0, 4, 1'b1);
    chk("popfull_no_overrun", overrun, 1'b0);
    chk("popfull_frame_bytes", frame_bytes, 6'd5);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("popfull_b%0d", k), 8'(8'h12 + k));
    @(negedge clk);
    chk("popfull_empty", rx_valid, 1'b0);

    // Reset in the middle of a byte with earlier bytes still queued.
    mo_bytes[0] = 8'hC3; mo_bytes[1] = 8'h3C; mo_bytes[2] = 8'hF0;
    tx_data = 8'hFF;
    send_frame(2, 3, -1, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_frame_bytes", frame_bytes, 6'd0);
    chk("midrst_overrun", overrun, 1'b0);
    rst = 1'b0;
    s0 = n_start;
    wait_clk(20);
    chk("midrst_no_start_while_low", n_start - s0, 0);
    chk("midrst_rx_valid_after", rx_valid, 1'b0);
    ss_n = 1'b1;
    wait_clk(10);
    tx_data = 8'h00;
    for (int k = 0; k < 7; k++) mo_bytes[k] = 8'(8'hA0 + 8'(k * 3));
    s0 = n_start;
    send_frame(7, 0, -1, 1'b1);
    chk("fresh_start_once", n_start - s0, 1);
    chk("fresh_frame_bytes", frame_bytes, 6'd7);
    chk("fresh_overrun", overrun, 1'b1);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("fresh_b%0d", k), 8'(8'hA0 + 8'(k * 3)));

    // Rerun after clearing the overrun so all seven bytes fit when drained as they arrive.
    do_reset();
    for (int k = 0; k < 7; k++) mo_bytes[k] = 8'(8'hA0 + 8'(k * 3));
    ss_n = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 7; k++) begin
      logic m;
      for (int i = 7; i >= 0; i--) spi_bit(mo_bytes[k][i], 1'b0, m);
      wait_clk(6);
      pop_chk($sformatf("fresh7_b%0d", k), mo_bytes[k]);
    end
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(10);
    chk("fresh7_frame_bytes", frame_bytes, 6'd7);
    chk("fresh7_no_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
